cluster_packer: RTL and testbench
=================================

CLUSTER_PACKER -- requirements
Module: cluster_packer

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 Port `clock4x` SHALL be an input, 1 bit wide: the single clock; all state updates occur on its rising edge.
REQ-003 Port `global_reset` SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-004 Ports `vfat0` .. `vfat23` SHALL be inputs, 64 bits wide each: S-bits, with `vfatN[i]` at global strip address N*64+i (0..1535).
REQ-005 Port `truncate_clusters` SHALL be an input, 1 bit wide: 1 = drop the strips of a run beyond 8; 0 = continue the run as new clusters.
REQ-006 Ports `cluster0` .. `cluster7` SHALL be outputs, 14 bits wide each: [13:11] cnt (cluster size minus 1), [10:0] adr (first strip).

Function
REQ-007 The block SHALL concatenate the inputs into sbits[1535:0], with vfat0 in bits [63:0].
REQ-008 A cluster SHALL start at strip i when sbits[i]=1 and (i=0 or sbits[i-1]=0); runs SHALL span VFAT boundaries.
REQ-009 cnt SHALL equal the number of consecutive set strips from the start, minus 1, saturating at 7 (8 strips).
REQ-010 With truncate_clusters=0, strip i+8 of a run still set SHALL start a new cluster, repeating every 8 strips.
REQ-011 With truncate_clusters=1, strips beyond the 8th of a run SHALL NOT generate clusters.
REQ-012 Clusters SHALL be reported in ascending adr order, the lowest on cluster0; clusters beyond the 8th SHALL be discarded.
REQ-013 Unused cluster slots SHALL output adr=11'h7FE, cnt=0 (invalid marker).
REQ-014 Latency SHALL be exactly 3 clock4x cycles, input sample to output, fully pipelined, accepting a new input every cycle.
REQ-015 truncate_clusters SHALL be sampled in the same pipeline stage as the S-bits it applies to.

Reset
REQ-016 While global_reset=0, all pipeline registers SHALL clear, and every cluster output SHALL read adr=11'h7FE, cnt=0.
REQ-017 After reset deasserts, the first valid output SHALL appear 3 cycles after the first sampled input; reset mid-operation SHALL flush in-flight data.

Configuration
REQ-018 Macro `CLUSTER_OVERFLOW_FLAG_EN`, when defined, SHALL add output `overflow` (1 bit).
REQ-019 `overflow` SHALL be high in the same cycle as the associated clusters when more than 8 clusters were found; it SHALL reset to 0.
REQ-020 Without `CLUSTER_OVERFLOW_FLAG_EN`, the port and its logic SHALL be absent, with no other behavioural change.

Structure
REQ-021 Package `cluster_packer_pkg` SHALL hold the following constants: NUM_VFATS=24, SBITS_PER_VFAT=64, NUM_SBITS=1536, NUM_CLUSTERS=8, MAX_CNT=7, INVALID_ADR=11'h7FE.
REQ-022 Package `cluster_packer_pkg` SHALL hold a cluster typedef {cnt[2:0], adr[10:0]}.
REQ-023 Sub-module `cluster_finder` SHALL compute the per-strip cluster-start mask and the per-strip cnt (pipeline stage 2).
REQ-024 The top level SHALL perform input registration (stage 1) and the ordered selection of the 8 lowest clusters (stage 3).

Verification
REQ-025 Single strip, sbits=1536'd2 (vfat0=64'h2) -> cluster0 = adr 1, cnt 0; cluster1..7 invalid (adr 7FE).
REQ-026 Pairs, vfat0=vfat3=...=vfat21 (every third VFAT)=64'h3 -> cluster0..7 = adr 0,192,384,576,768,960,1152,1344, each cnt 1.
REQ-027 Alternating, vfat0=64'hAAAAAAAAA -> cluster0..7 = adr 1,3,5,7,9,11,13,15, cnt 0; with OVERFLOW_EN, overflow=1.
REQ-028 All 1536 strips set, truncate=0 -> adr 0,8,16,24,32,40,48,56, cnt 7 each.
REQ-029 All 1536 strips set, truncate=1 -> cluster0 = adr 0, cnt 7; all others invalid.
REQ-030 Reset and latency: hold reset low with nonzero inputs -> all outputs invalid; after release, the first input appears 3 cycles later.
REQ-031 Back-to-back distinct patterns -> outputs change on consecutive cycles.

Source files
------------

// File: rtl/cluster_packer_pkg.sv
// Shared constants and the cluster record for the S-bit cluster packer.
package cluster_packer_pkg;

  localparam int NUM_VFATS      = 24;
  localparam int SBITS_PER_VFAT = 64;
  localparam int NUM_SBITS      = 1536;
  localparam int NUM_CLUSTERS   = 8;
  localparam int MAX_CNT        = 7;
  localparam logic [10:0] INVALID_ADR = 11'h7FE;

  typedef struct packed {
    logic [2:0]  cnt;
    logic [10:0] adr;
  } cluster_t;

  localparam cluster_t INVALID_CLUSTER = '{cnt: 3'd0, adr: INVALID_ADR};

endpackage

// File: rtl/cluster_packer_cluster_finder.sv
// Stage 2: per-strip cluster-start mask and per-strip size (cnt), registered.
module cluster_finder
  import cluster_packer_pkg::*;
(
  input  logic                           gclk,
  input  logic                           grst_n,
  input  logic [NUM_SBITS-1:0]           sbits,
  input  logic                           truncate,
  output logic [NUM_SBITS-1:0]           start_q,
  output logic [NUM_SBITS-1:0][2:0]      cnt_q
);

  logic [NUM_SBITS-1:0]      start_d;
  logic [NUM_SBITS-1:0][2:0] cnt_d;

  always_comb begin : find
    logic [2:0] pos;
    logic [3:0] run;
    logic       prev;
    start_d = '0;
    cnt_d   = '0;
    pos     = '0;
    prev    = 1'b0;
    // pos wraps every 8 set strips, so long runs restart a cluster each wrap
    for (int i = 0; i < NUM_SBITS; i++) begin
      if (sbits[i]) begin
        start_d[i] = (pos == 3'd0) && !(truncate && prev);
        pos        = pos + 3'd1;
      end else begin
        pos = '0;
      end
      prev = sbits[i];
    end
    // run = set strips from i upward, saturating at 8
    run = '0;
    for (int i = NUM_SBITS - 1; i >= 0; i--) begin
      if (sbits[i]) run = (run == 4'd8) ? 4'd8 : run + 4'd1;
      else          run = '0;
      cnt_d[i] = sbits[i] ? 3'(run - 4'd1) : 3'd0;
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      start_q <= '0;
      cnt_q   <= '0;
    end else begin
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/cluster_packer.sv
// S-bit cluster packer: 3-stage pipeline (input reg, cluster find, 8-lowest select).
// Optional `overflow` output is enabled by defining CLUSTER_OVERFLOW_FLAG_EN.
module cluster_packer
  import cluster_packer_pkg::*;
(
  input  logic        clock4x,
  input  logic        global_reset,
  input  logic [63:0] vfat0,  input  logic [63:0] vfat1,  input  logic [63:0] vfat2,
  input  logic [63:0] vfat3,  input  logic [63:0] vfat4,  input  logic [63:0] vfat5,
  input  logic [63:0] vfat6,  input  logic [63:0] vfat7,  input  logic [63:0] vfat8,
  input  logic [63:0] vfat9,  input  logic [63:0] vfat10, input  logic [63:0] vfat11,
  input  logic [63:0] vfat12, input  logic [63:0] vfat13, input  logic [63:0] vfat14,
  input  logic [63:0] vfat15, input  logic [63:0] vfat16, input  logic [63:0] vfat17,
  input  logic [63:0] vfat18, input  logic [63:0] vfat19, input  logic [63:0] vfat20,
  input  logic [63:0] vfat21, input  logic [63:0] vfat22, input  logic [63:0] vfat23,
  input  logic        truncate_clusters,
  output logic [13:0] cluster0, output logic [13:0] cluster1,
  output logic [13:0] cluster2, output logic [13:0] cluster3,
  output logic [13:0] cluster4, output logic [13:0] cluster5,
  output logic [13:0] cluster6, output logic [13:0] cluster7
`ifdef CLUSTER_OVERFLOW_FLAG_EN
  ,
  output logic        overflow
`endif
);

  logic [NUM_SBITS-1:0]           sbits_q;
  logic                           trunc_q;
  logic [NUM_SBITS-1:0]           start_q;
  logic [NUM_SBITS-1:0][2:0]      cnt_q;
  cluster_t [NUM_CLUSTERS-1:0]    sel_d, sel_q;
  logic [10:0]                    found;

  always_ff @(posedge clock4x or negedge global_reset) begin
    if (!global_reset) begin
      sbits_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      sbits_q <= {vfat23, vfat22, vfat21, vfat20, vfat19, vfat18, vfat17, vfat16,
                  vfat15, vfat14, vfat13, vfat12, vfat11, vfat10, vfat9,  vfat8,
                  vfat7,  vfat6,  vfat5,  vfat4,  vfat3,  vfat2,  vfat1,  vfat0};
      trunc_q <= truncate_clusters;
    end
  end

  cluster_finder u_finder (
    .gclk     (clock4x),
    .grst_n   (global_reset),
    .sbits    (sbits_q),
    .truncate (trunc_q),
    .start_q  (start_q),
    .cnt_q    (cnt_q)
  );

  // Priority scan from strip 0: the first 8 starts fill slots in order
  always_comb begin
    sel_d = {NUM_CLUSTERS{INVALID_CLUSTER}};
    found = '0;
    for (int i = 0; i < NUM_SBITS; i++) begin
      if (start_q[i]) begin
        if (found < 11'(NUM_CLUSTERS)) sel_d[found[2:0]] = '{cnt: cnt_q[i], adr: 11'(i)};
        found = found + 11'd1;
      end
    end
  end

  always_ff @(posedge clock4x or negedge global_reset) begin
    if (!global_reset) sel_q <= {NUM_CLUSTERS{INVALID_CLUSTER}};
    else               sel_q <= sel_d;
  end

`ifdef CLUSTER_OVERFLOW_FLAG_EN
  always_ff @(posedge clock4x or negedge global_reset) begin
    if (!global_reset) overflow <= 1'b0;
    else               overflow <= (found > 11'(NUM_CLUSTERS));
  end
`endif

  assign cluster0 = sel_q[0];
  assign cluster1 = sel_q[1];
  assign cluster2 = sel_q[2];
  assign cluster3 = sel_q[3];
  assign cluster4 = sel_q[4];
  assign cluster5 = sel_q[5];
  assign cluster6 = sel_q[6];
  assign cluster7 = sel_q[7];

endmodule

// File: tb/tb_cluster_packer.sv
// Self-checking bench for cluster_packer: directed patterns, random traffic, reset flush.
module tb_cluster_packer;

  logic        clock4x = 1'b0;
  logic        global_reset;
  logic [63:0] vfat [24];
  logic        truncate_clusters;
  logic [13:0] cluster0, cluster1, cluster2, cluster3;
  logic [13:0] cluster4, cluster5, cluster6, cluster7;
`ifdef CLUSTER_OVERFLOW_FLAG_EN
  logic        overflow;
`endif

  int checks = 0;
  int errors = 0;

  logic [111:0] pend_cl [$];
  int           pend_n  [$];

  always #5 clock4x = ~clock4x;

  cluster_packer dut (
    .clock4x(clock4x), .global_reset(global_reset),
    .vfat0(vfat[0]),   .vfat1(vfat[1]),   .vfat2(vfat[2]),   .vfat3(vfat[3]),
    .vfat4(vfat[4]),   .vfat5(vfat[5]),   .vfat6(vfat[6]),   .vfat7(vfat[7]),
    .vfat8(vfat[8]),   .vfat9(vfat[9]),   .vfat10(vfat[10]), .vfat11(vfat[11]),
    .vfat12(vfat[12]), .vfat13(vfat[13]), .vfat14(vfat[14]), .vfat15(vfat[15]),
    .vfat16(vfat[16]), .vfat17(vfat[17]), .vfat18(vfat[18]), .vfat19(vfat[19]),
    .vfat20(vfat[20]), .vfat21(vfat[21]), .vfat22(vfat[22]), .vfat23(vfat[23]),
    .truncate_clusters(truncate_clusters),
    .cluster0(cluster0), .cluster1(cluster1), .cluster2(cluster2), .cluster3(cluster3),
    .cluster4(cluster4), .cluster5(cluster5), .cluster6(cluster6), .cluster7(cluster7)
`ifdef CLUSTER_OVERFLOW_FLAG_EN
    , .overflow(overflow)
`endif
  );

  function automatic logic [111:0] inv_vec();
    logic [111:0] v;
    for (int j = 0; j < 8; j++) v[j*14 +: 14] = {3'd0, 11'h7FE};
    return v;
  endfunction

  // Reference: walk whole runs, cut each into 8-strip clusters (or one, if truncating)
  function automatic void model(input logic [1535:0] sb, input logic tr,
                                output logic [111:0] cl, output int n);
    int starts [$];
    int cnts [$];
    int i, r, len;
    i = 0;
    while (i < 1536) begin
      if (sb[i]) begin
        r = i; len = 0;
        while (i < 1536 && sb[i]) begin len++; i++; end
        for (int k = 0; k < len; k += 8)
          if (!(tr && k > 0)) begin
            starts.push_back(r + k);
            cnts.push_back(((len - k) > 8 ? 8 : (len - k)) - 1);
          end
      end else i++;
    end
    cl = inv_vec();
    for (int j = 0; j < 8 && j < starts.size(); j++)
      cl[j*14 +: 14] = {3'(cnts[j]), 11'(starts[j])};
    n = starts.size();
  endfunction

  task automatic check(input string tag, input logic [111:0] exp, input int n);
    logic [111:0] obs;
    int nv, nexp;
    obs = {cluster7, cluster6, cluster5, cluster4, cluster3, cluster2, cluster1, cluster0};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s clusters got %h exp %h", tag, obs, exp);
    end
    nv = 0;
    for (int j = 0; j < 8; j++) if (obs[j*14 +: 11] !== 11'h7FE) nv++;
    nexp = (n > 8) ? 8 : n;
    checks++;
    assert (nv === nexp) else begin
      errors++;
      $error("FAIL %s_count got %0d exp %0d", tag, nv, nexp);
    end
`ifdef CLUSTER_OVERFLOW_FLAG_EN
    checks++;
    assert (overflow === (n > 8)) else begin
      errors++;
      $error("FAIL %s_overflow got %b exp %b", tag, overflow, (n > 8));
    end
`endif
  endtask

  task automatic drive(input logic [1535:0] sb, input logic tr);
    for (int k = 0; k < 24; k++) vfat[k] = sb[k*64 +: 64];
    truncate_clusters = tr;
  endtask

  task automatic preload();
    pend_cl.delete();
    pend_n.delete();
    repeat (2) begin pend_cl.push_back(inv_vec()); pend_n.push_back(0); end
  endtask

  // Called at a negedge; output checked three sampling edges after this input.
  task automatic apply(input string tag, input logic [1535:0] sb, input logic tr);
    logic [111:0] cl;
    int n;
    drive(sb, tr);
    model(sb, tr, cl, n);
    pend_cl.push_back(cl);
    pend_n.push_back(n);
    @(posedge clock4x);
    @(negedge clock4x);
    check(tag, pend_cl.pop_front(), pend_n.pop_front());
  endtask

  function automatic logic [1535:0] rand_sbits(input int mode);
    logic [1535:0] sb;
    int s, len;
    sb = '0;
    case (mode)
      0: for (int k = 0; k < 48; k++) sb[k*32 +: 32] = $urandom & $urandom & $urandom;
      1: for (int k = 0; k < 48; k++) sb[k*32 +: 32] = $urandom;
      2: repeat (1 + $urandom_range(0, 4)) begin
           s = $urandom_range(0, 1535);
           len = $urandom_range(1, 40);
           for (int b = s; b < s + len && b < 1536; b++) sb[b] = 1'b1;
         end
      default: repeat ($urandom_range(0, 10)) sb[$urandom_range(0, 1535)] = 1'b1;
    endcase
    return sb;
  endfunction

  initial begin
    logic [1535:0] sb;
    global_reset = 1'b0;
    drive('1, 1'b0);
    repeat (3) @(posedge clock4x);
    @(negedge clock4x);
    check("reset_hold", inv_vec(), 0);
    @(negedge clock4x);
    check("reset_hold2", inv_vec(), 0);

    global_reset = 1'b1;
    preload();

    sb = 1536'd2;
    apply("single", sb, 1'b0);
    sb = '0;
    for (int k = 0; k < 24; k += 3) sb[k*64 +: 64] = 64'h3;
    apply("pairs", sb, 1'b0);
    sb = '0; sb[63:0] = 64'hAAAAAAAAA;
    apply("alternate", sb, 1'b0);
    apply("all_notrunc", '1, 1'b0);
    apply("all_trunc", '1, 1'b1);
    sb = '0; sb[70:50] = '1;
    apply("run21_notrunc", sb, 1'b0);
    apply("run21_trunc", sb, 1'b1);
    sb = '0; sb[1535:1530] = '1; sb[64:56] = '1;
    apply("edges", sb, 1'b0);
    apply("zero", '0, 1'b0);

    for (int t = 0; t < 40; t++)
      apply($sformatf("rand%0d", t), rand_sbits(t % 4), 1'($urandom_range(0, 1)));

    // Asynchronous reset mid-stream: outputs go invalid at once and in-flight data is lost
    apply("pre_flush_a", rand_sbits(1), 1'b0);
    apply("pre_flush_b", rand_sbits(2), 1'b0);
    #2 global_reset = 1'b0;
    #1 check("flush_async", inv_vec(), 0);
    @(posedge clock4x);
    @(negedge clock4x);
    check("flush_hold", inv_vec(), 0);
    global_reset = 1'b1;
    preload();
    for (int t = 0; t < 8; t++)
      apply($sformatf("post%0d", t), rand_sbits(t % 4), 1'($urandom_range(0, 1)));
    repeat (2) apply("drain", '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
